// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared widths and FSM encoding for the data-memory responder
package dmem_responder_pkg;

    localparam int WORD_W      = 16;
    localparam int DMEM_DATA_W = WORD_W;
    localparam int DMEM_ADDR_W = WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word array, one write port and a registered read port
module dmem_array import dmem_responder_pkg::*; #(
    parameter  int DEPTH  = 256,
    parameter  int DATA_W = DMEM_DATA_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable wait states
// and a busy output for pipeline stalling.
module dmem_responder import dmem_responder_pkg::*; #(
    parameter int          DATA_W   = DMEM_DATA_W,
    parameter int          ADDR_W   = DMEM_ADDR_W,
    parameter int          DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] arr_rdata;
    logic              rsp_valid_q, rsp_err_q, rd_oor_q;
    logic              accept, done, oor;

    assign accept = req_valid && state_q == IDLE;
    assign done   = state_q == DONE;
    // Any set bit above the index field means out of range, so no aliasing.
    assign oor    = (addr_q >> AW) != '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = WAIT_CYC == 0 ? DONE : WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? DONE : WAIT;
                cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_oor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= done;
            rsp_err_q   <= done && oor;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (done && !wr_q) rd_oor_q <= oor;
        end
    end

    dmem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
        .clk    (clk),
        .rst_ni (rst),
        .we_i   (done && wr_q && !oor),
        .re_i   (done && !wr_q && !oor),
        .addr_i (addr_q[AW-1:0]),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    // Read data is held until the next load; an out-of-range load reads as zero.
    assign rsp_rdata = rd_oor_q ? '0 : arr_rdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE || accept;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder with a behavioural memory model
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WC    = 2;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_write = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;

    logic        z_valid = 0, z_write = 0;
    logic [15:0] z_addr = 0, z_wdata = 0;
    logic        z_ready, z_rsp_valid, z_err, z_busy;
    logic [15:0] z_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(WC)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(0)) u_zero (
        .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready),
        .req_write(z_write), .req_addr(z_addr), .req_wdata(z_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err), .busy(z_busy)
    );

    typedef struct {
        logic        wr;
        logic        err;
        logic        chk;
        logic [15:0] data;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem [DEPTH];
    bit          known [DEPTH];
    logic [15:0] last_load = 0;
    bit          last_known = 1;
    int          checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a request's response is fully determined by memory state at its accept.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, output int acc);
        exp_t e;
        int   n = 0;
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 40) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 0; acc = -1;
            return;
        end
        acc   = cyc;
        e.wr  = w;
        e.err = a >= DEPTH;
        e.acc = cyc;
        if (w) begin
            e.chk = last_known;
            e.data = last_load;
            if (!e.err) begin mem[a[7:0]] = d; known[a[7:0]] = 1; end
        end else begin
            e.chk = e.err || known[a[7:0]];
            e.data = e.err ? 16'h0 : mem[a[7:0]];
            last_load = e.data; last_known = e.chk;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (q.size() > 0 && n < 100) begin @(negedge clk); n++; end
        if (q.size() > 0) begin check("drain_timeout", q.size(), 0); q.delete(); end
        @(negedge clk);
    endtask

    task automatic zreq(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] expd);
        z_valid = 1; z_write = w; z_addr = a; z_wdata = d;
        #2;
        check("z_ready_accept", z_ready, 1);
        check("z_busy_accept", z_busy, 1);
        @(negedge clk); z_valid = 0; #2;
        check("z_busy_done", z_busy, 1);
        check("z_ready_done", z_ready, 0);
        check("z_rsp_early", z_rsp_valid, 0);
        @(negedge clk); #2;
        check("z_rsp_valid", z_rsp_valid, 1);
        check("z_rsp_err", z_err, 0);
        if (!w) check("z_rdata", z_rdata, expd);
        check("z_busy_after", z_busy, 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        int   o;
        bit   pend;
        #2;
        if (!rst) pend = 0;
        else begin
            if (pend) check("valid_held", req_valid, 1);
            pend = req_valid && !req_ready;
            if (rsp_valid) begin
                if (q.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    e = q.pop_front();
                    check("latency", cyc - e.acc, WC + 2);
                    check("rsp_err", rsp_err, e.err);
                    if (e.chk) check(e.wr ? "rdata_hold" : "rdata", rsp_rdata, e.data);
                end
            end else check("err_idle", rsp_err, 0);
            o = 0;
            foreach (q[i]) if (q[i].acc < cyc) o++;
            check("req_ready", req_ready, o == 0);
            check("busy", busy, o > 0 || req_valid);
        end
    end

    initial begin
        int acc;
        int accs [4];
        #1 rst = 0;
        #2;
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err", rsp_err, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);

        issue(1, 16'd5, 16'h1111, acc);
        drain();
        issue(1, 16'd5, 16'hBEEF, acc);
        rst = 0; idle();
        mem[5] = 16'h1111;
        q.delete();
        #1;
        check("abort_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_err", rsp_err, 0);
        check("abort_rdata", rsp_rdata, 0);
        last_load = 0; last_known = 1;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        issue(0, 16'd5, 16'h0, acc);
        drain();

        issue(1, 16'h0010, 16'h1234, acc);
        drain();
        issue(0, 16'h0010, 16'h0, acc);
        drain();

        for (int i = 0; i < 4; i++) issue(1, 16'(i), 16'(16'hA0 + i), acc);
        drain();
        for (int i = 0; i < 4; i++) issue(0, 16'(i), 16'h0, accs[i]);
        drain();
        for (int i = 1; i < 4; i++) check("b2b_spacing", accs[i] - accs[i-1], WC + 2);

        issue(1, 16'h0000, 16'h5A5A, acc);
        drain();
        issue(1, 16'h0100, 16'hFFFF, acc);
        drain();
        issue(0, 16'h0000, 16'h0, acc);
        drain();
        issue(0, 16'h0100, 16'h0, acc);
        drain();

        zreq(1, 16'd3, 16'h00A5, 16'h0);
        zreq(0, 16'd3, 16'h0, 16'h00A5);

        repeat (300) begin
            logic        w;
            logic [15:0] a;
            int          gap;
            w = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 9) == 0 ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 255));
            issue(w, a, 16'($urandom), acc);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin idle(); repeat (gap) @(negedge clk); end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
